// File: rtl/tx_fifo.sv
// tx_fifo: single-clock transmit FIFO between the APB register block and the
// I2S serializer. Words are pushed with Tx_wen and popped with rd_en; a popped
// word appears on rd_data together with a one-cycle rd_valid pulse.
//
// Ports:
//   pclk, preset       clock, asynchronous active-high reset
//   Tx_wen, Tx_data    write strobe and 32-bit write data
//   rd_en              read request; rd_data/rd_valid follow one cycle later
//   clr_err            clears the sticky ovf/udf flags (a new error wins)
//   rd_data, rd_valid  read data and its one-cycle qualifier
//   Tx_full, Tx_empty, Tx_afull, level   occupancy status
//   ovf, udf           sticky dropped-write / empty-read flags
module tx_fifo #(
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       Tx_wen,
  input  logic [31:0]                Tx_data,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [31:0]                rd_data,
  output logic                       rd_valid,
  output logic                       Tx_full,
  output logic                       Tx_empty,
  output logic                       Tx_afull,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic                       udf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          rd_acc, wr_acc;

  assign Tx_full  = (level == LW'(DEPTH));
  assign Tx_empty = (level == '0);
  assign Tx_afull = (level >= LW'(AFULL_TH));

  // A read frees a slot in the same cycle, so a write at full is still
  // accepted when paired with a read. Reads never see a same-cycle write
  // because emptiness comes from the registered level.
  assign rd_acc = rd_en && !Tx_empty;
  assign wr_acc = Tx_wen && (!Tx_full || rd_acc);

  // Storage is intentionally not reset.
  always_ff @(posedge pclk) begin
    if (wr_acc) mem[wp] <= Tx_data;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rp];
        rp      <= rp + 1'b1;
      end
      if (wr_acc) wp <= wp + 1'b1;

      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Set has priority over clear.
      if (Tx_wen && !wr_acc) ovf <= 1'b1;
      else if (clr_err)      ovf <= 1'b0;
      if (rd_en && Tx_empty) udf <= 1'b1;
      else if (clr_err)      udf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tx_fifo.sv
module tb_tx_fifo;
  localparam int DEPTH    = 8;
  localparam int AFULL_TH = 6;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        Tx_wen = 1'b0;
  logic [31:0] Tx_data = '0;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid, Tx_full, Tx_empty, Tx_afull, ovf, udf;
  logic [$clog2(DEPTH):0] level;

  tx_fifo #(.DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .pclk(pclk), .preset(preset), .Tx_wen(Tx_wen), .Tx_data(Tx_data),
    .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
    .Tx_full(Tx_full), .Tx_empty(Tx_empty), .Tx_afull(Tx_afull),
    .level(level), .ovf(ovf), .udf(udf)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a plain queue of words.
  logic [31:0] q[$];
  logic [31:0] exp_q[$];   // scoreboard of words the DUT owes on rd_data
  logic [31:0] m_data = '0;
  bit          m_valid = 0, m_ovf = 0, m_udf = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("level",    level,    q.size());
    chk("Tx_full",  Tx_full,  q.size() == DEPTH);
    chk("Tx_empty", Tx_empty, q.size() == 0);
    chk("Tx_afull", Tx_afull, q.size() >= AFULL_TH);
    chk("ovf",      ovf,      m_ovf);
    chk("udf",      udf,      m_udf);
    chk("rd_valid", rd_valid, m_valid);
    chk("rd_data",  rd_data,  m_data);
  endtask

  task automatic model_reset();
    q.delete(); exp_q.delete();
    m_data = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
  endtask

  // One clock cycle of stimulus; the model decides what the DUT must do.
  task automatic cyc(bit wen, logic [31:0] d, bit ren, bit clr);
    bit rda, wra;
    int sz;
    @(negedge pclk);
    Tx_wen = wen; Tx_data = d; rd_en = ren; clr_err = clr;
    sz  = q.size();
    rda = ren && sz > 0;
    wra = wen && (sz < DEPTH || rda);
    if (rda) begin
      m_data = q.pop_front();
      exp_q.push_back(m_data);
    end
    if (wra) q.push_back(d);
    m_valid = rda;
    if (wen && !wra) m_ovf = 1; else if (clr) m_ovf = 0;
    if (ren && sz == 0) m_udf = 1; else if (clr) m_udf = 0;
    @(posedge pclk);
    #1 check_state();
  endtask

  // Monitor: every rd_valid must match the oldest owed word.
  always @(negedge pclk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", 1, 0);
      end else begin
        chk("rd_word", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    model_reset();
    #1 check_state();

    // Fill 0x11..0x88 then check overflow
    for (int i = 1; i <= 8; i++) cyc(1, 32'h11 * i, 0, 0);
    cyc(1, 32'hDEAD, 0, 0);
    // Drain; only the original data must come back
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);   // clr_err clears ovf

    // Simultaneous read+write at full
    for (int i = 0; i < 8; i++) cyc(1, 32'hA0 + i, 0, 0);
    cyc(1, 32'hBEEF, 1, 0);
    cyc(1, 32'hBEE0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);

    // Level 3, 20 concurrent cycles across pointer wraps
    for (int i = 0; i < 3; i++) cyc(1, 32'hC0 + i, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, $urandom, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

    // Underflow and no bypass
    cyc(0, 0, 1, 0);
    cyc(1, 32'h5A, 1, 0);
    cyc(0, 0, 1, 0);
    // clr_err coinciding with a new underflow: set wins
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    // Level 1: read returns the older word, the new one stays
    cyc(1, 32'h61, 0, 0);
    cyc(1, 32'h62, 1, 0);
    cyc(0, 0, 1, 0);

    // Reset mid-operation at level 5 with a read pending
    for (int i = 0; i < 5; i++) cyc(1, 32'hE0 + i, 0, 0);
    cyc(1, 32'hEE, 0, 0);      // level 6 -> afull
    cyc(0, 0, 1, 0);           // back to level 5
    cyc(0, 0, 0, 0);
    @(negedge pclk);
    Tx_wen = 0; rd_en = 1; clr_err = 0;
    #2 preset = 1'b1;
    model_reset();
    #1 check_state();
    @(posedge pclk);
    #1 check_state();
    @(negedge pclk);
    preset = 1'b0; rd_en = 0;
    #1 check_state();

    // Randomized traffic with occasional error clears
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 45),
          ($urandom_range(0, 19) == 0));
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
